// File: rtl/sccb_pkg.sv
// Shared constants and state encodings for the SCCB write master.
package sccb_pkg;

    localparam int unsigned SHIFT_W         = 32;
    localparam int unsigned BYTES_PER_WRITE = 4;
    localparam int unsigned TICK_CNT_W      = 16;

    localparam logic [7:0] OV5640_DEV_ADDR = 8'h78;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/sccb_write_master_qtr_tick.sv
// Quarter-period tick generator; tick is registered and lands on the cycle the count reaches QTR_CYCLES-1.
module sccb_qtr_tick
    import sccb_pkg::*;
#(
    parameter int unsigned QTR_CYCLES = 312
) (
    input  logic clk_25m,
    input  logic camera_rstn,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [TICK_CNT_W-1:0] CNT_LAST = TICK_CNT_W'(QTR_CYCLES - 1);
    localparam logic [TICK_CNT_W-1:0] CNT_PRE  = TICK_CNT_W'(QTR_CYCLES - 2);

    logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
    logic                  tick_q, tick_d;

    // Tick is precomputed one count early so the registered pulse aligns with CNT_LAST.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + TICK_CNT_W'(1);
            tick_d = (cnt_q == CNT_PRE);
        end
    end

    always_ff @(posedge clk_25m) begin
        if (!camera_rstn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/sccb_write_master.sv
// SCCB/I2C 4-byte write engine: START, 4 ACKed bytes MSB first, STOP, then a level start/tr_end handshake.
module sccb_write_master
    import sccb_pkg::*;
#(
    parameter int unsigned QTR_CYCLES = 312
) (
    input  logic               clk_25m,
    input  logic               camera_rstn,
    input  logic               start,
    input  logic [SHIFT_W-1:0] i2c_data,
    output logic               busy,
    output logic               tr_end,
    output logic               ack_err,
    output logic               i2c_sclk,
    inout  wire                i2c_sdat
);

    state_t             state_q, state_d;
    logic [1:0]         qtr_q, qtr_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               scl_q, scl_d;
    logic               sda_oe_q, sda_oe_d;
    logic               busy_q, busy_d;
    logic               tr_end_q, tr_end_d;
    logic               ack_err_q, ack_err_d;
    logic [1:0]         sda_sync_q, sda_sync_d;

    logic run_c;
    logic clr_c;
    logic tick;

    assign run_c = (state_q != ST_IDLE) && (state_q != ST_DONE);

    sccb_qtr_tick #(
        .QTR_CYCLES (QTR_CYCLES)
    ) u_qtr_tick (
        .clk_25m     (clk_25m),
        .camera_rstn (camera_rstn),
        .run         (run_c),
        .clr         (clr_c),
        .tick        (tick)
    );

    // Open-drain: only ever pull low or release.
    assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;

    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        scl_d      = scl_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        tr_end_d   = tr_end_q;
        ack_err_d  = ack_err_q;
        sda_sync_d = {sda_sync_q[0], i2c_sdat};
        clr_c      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d    = i2c_data;
                    busy_d     = 1'b1;
                    ack_err_d  = 1'b0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    qtr_d      = Q0;
                    clr_c      = 1'b1;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (qtr_q == Q0) begin
                        scl_d    = 1'b1;
                        sda_oe_d = 1'b0;
                        qtr_d    = Q1;
                    end else begin
                        sda_oe_d   = 1'b1;
                        qtr_d      = Q0;
                        bit_cnt_d  = 3'd7;
                        byte_cnt_d = '0;
                        state_d    = ST_BIT;
                    end
                end
            end

            ST_BIT: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        Q0: begin
                            scl_d    = 1'b0;
                            sda_oe_d = ~shift_q[SHIFT_W-1];
                        end
                        Q1: scl_d = 1'b0;
                        Q2: scl_d = 1'b1;
                        default: begin
                            scl_d     = 1'b1;
                            shift_d   = {shift_q[SHIFT_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            if (bit_cnt_q == 3'd0) begin
                                state_d = ST_ACK;
                            end
                        end
                    endcase
                end
            end

            ST_ACK: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    case (qtr_q)
                        Q0, Q1: begin
                            scl_d    = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                        Q2: scl_d = 1'b1;
                        default: begin
                            scl_d = 1'b1;
                            // Slave drove SDA during SCL low; synchronised value is stable by now.
                            if (sda_sync_q[1]) begin
                                ack_err_d = 1'b1;
                                state_d   = ST_STOP;
                            end else if (byte_cnt_q == 2'(BYTES_PER_WRITE - 1)) begin
                                state_d = ST_STOP;
                            end else begin
                                byte_cnt_d = byte_cnt_q + 2'd1;
                                bit_cnt_d  = 3'd7;
                                state_d    = ST_BIT;
                            end
                        end
                    endcase
                end
            end

            ST_STOP: begin
                if (tick) begin
                    case (qtr_q)
                        Q0: begin
                            scl_d    = 1'b0;
                            sda_oe_d = 1'b1;
                            qtr_d    = Q1;
                        end
                        Q1: begin
                            scl_d = 1'b1;
                            qtr_d = Q2;
                        end
                        default: begin
                            scl_d    = 1'b1;
                            sda_oe_d = 1'b0;
                            qtr_d    = Q0;
                            tr_end_d = 1'b1;
                            state_d  = ST_DONE;
                        end
                    endcase
                end
            end

            ST_DONE: begin
                if (!start) begin
                    tr_end_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_25m) begin
        if (!camera_rstn) begin
            state_q    <= ST_IDLE;
            qtr_q      <= Q0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            tr_end_q   <= 1'b0;
            ack_err_q  <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            qtr_q      <= qtr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            tr_end_q   <= tr_end_d;
            ack_err_q  <= ack_err_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    assign busy     = busy_q;
    assign tr_end   = tr_end_q;
    assign ack_err  = ack_err_q;
    assign i2c_sclk = scl_q;

endmodule

// File: tb/tb_sccb_write_master.sv
// Directed bench for sccb_write_master with a pulled-up SDA, a scripted ACK/NACK slave and a byte scoreboard.
module tb_sccb_write_master;
    import sccb_pkg::*;

    localparam int unsigned QTR       = 4;
    localparam int unsigned FRAME_CYC = 149 * QTR;

    logic        clk_25m = 1'b0;
    logic        camera_rstn;
    logic        start;
    logic [31:0] i2c_data;
    logic        busy, tr_end, ack_err, i2c_sclk;
    wire         sda_w;

    always #20 clk_25m = ~clk_25m;

    sccb_write_master #(
        .QTR_CYCLES (QTR)
    ) dut (
        .clk_25m     (clk_25m),
        .camera_rstn (camera_rstn),
        .start       (start),
        .i2c_data    (i2c_data),
        .busy        (busy),
        .tr_end      (tr_end),
        .ack_err     (ack_err),
        .i2c_sclk    (i2c_sclk),
        .i2c_sdat    (sda_w)
    );

    // Bus: pull-up plus slave open-drain driver.
    logic slave_low = 1'b0;
    pullup (sda_w);
    assign sda_w = slave_low ? 1'b0 : 1'bz;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [3:0] nack_mask = 4'b0000;
    int         rd_ptr    = 0;

    // Slave/monitor state, written only by the monitor process.
    logic [7:0] rx_log [64];
    int         rx_cnt      = 0;
    int         bitpos      = 0;
    int         byte_idx    = 0;
    logic [7:0] cur         = 8'h00;
    logic       in_frame    = 1'b0;
    int         starts      = 0;
    int         stops       = 0;
    int         viol        = 0;
    int         frame_rises = 0;
    int         last_rises  = 0;
    int         total_rises = 0;
    logic       prev_scl    = 1'b1;
    logic       prev_sda    = 1'b1;
    logic       prev_busy   = 1'b0;
    logic       prev_tr_end = 1'b0;
    int         cyc         = 0;
    int         accept_cyc  = 0;
    int         trend_cyc   = 0;

    always @(posedge clk_25m) cyc <= cyc + 1;

    always @(negedge clk_25m) begin
        logic scl_s, sda_s;
        scl_s = i2c_sclk;
        sda_s = sda_w;
        if (!camera_rstn) begin
            in_frame  = 1'b0;
            slave_low = 1'b0;
        end else if (prev_scl && scl_s && (sda_s != prev_sda)) begin
            if (!sda_s) begin
                if (in_frame) viol++;
                starts++;
                in_frame    = 1'b1;
                bitpos      = 0;
                byte_idx    = 0;
                frame_rises = 0;
                slave_low   = 1'b0;
            end else begin
                if (!in_frame) viol++;
                stops++;
                in_frame   = 1'b0;
                last_rises = frame_rises;
                slave_low  = 1'b0;
            end
        end else if (!prev_scl && scl_s) begin
            total_rises++;
            if (in_frame) begin
                frame_rises++;
                if (bitpos < 8) cur = {cur[6:0], sda_s};
                bitpos++;
            end
        end else if (in_frame && prev_scl && !scl_s) begin
            if (bitpos == 8) begin
                slave_low = (byte_idx < 4) ? !nack_mask[byte_idx] : 1'b0;
                rx_log[rx_cnt % 64] = cur;
                rx_cnt++;
            end else if (bitpos == 9) begin
                slave_low = 1'b0;
                bitpos    = 0;
                byte_idx++;
            end
        end
        if (busy && !prev_busy)     accept_cyc = cyc;
        if (tr_end && !prev_tr_end) trend_cyc  = cyc;
        prev_scl    = scl_s;
        prev_sda    = sda_s;
        prev_busy   = busy;
        prev_tr_end = tr_end;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        while (rd_ptr < rx_cnt) begin
            if (exp_q.size() == 0) begin
                check({tag, "_extra"}, 32'(rx_log[rd_ptr % 64]), 32'hFFFF_FFFF);
            end else begin
                check(tag, 32'(rx_log[rd_ptr % 64]), 32'(exp_q.pop_front()));
            end
            rd_ptr++;
        end
        check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_tr_end(input string tag);
        for (int i = 0; i < 4 * FRAME_CYC && tr_end !== 1'b1; i++) @(negedge clk_25m);
        check(tag, 32'(tr_end), 32'd1);
        @(negedge clk_25m);
    endtask

    task automatic wait_busy(input string tag);
        for (int i = 0; i < 100 && busy !== 1'b1; i++) @(negedge clk_25m);
        check(tag, 32'(busy), 32'd1);
    endtask

    task automatic push_word(input logic [31:0] w, input int nbytes);
        logic [31:0] t;
        t = w;
        for (int b = 0; b < nbytes; b++) begin
            exp_q.push_back(t[31:24]);
            t = t << 8;
        end
    endtask

    initial begin
        int lat, s0, p0, r0, drops;

        // 1: reset with start held high
        camera_rstn = 1'b0;
        start       = 1'b1;
        i2c_data    = {OV5640_DEV_ADDR, 24'h30_0882};
        repeat (5) @(negedge clk_25m);
        check("rst_scl", 32'(i2c_sclk), 32'd1);
        check("rst_sda", 32'(sda_w), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tr_end", 32'(tr_end), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);

        // 2: full ACKed write
        push_word(32'h7830_0882, 4);
        s0 = starts; p0 = stops;
        camera_rstn = 1'b1;
        @(negedge clk_25m);
        check("accept_after_rst", 32'(busy), 32'd1);
        wait_tr_end("t2_tr_end");
        lat = trend_cyc - accept_cyc;
        n_checks++;
        assert (lat >= 595 && lat <= 597) else begin
            n_fail++;
            $error("FAIL latency: observed %0d expected 596+/-1", lat);
        end
        check("t2_ack_err", 32'(ack_err), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_starts", 32'(starts - s0), 32'd1);
        check("t2_stops", 32'(stops - p0), 32'd1);
        check("t2_scl_rises", 32'(last_rises), 32'd37);
        drain("t2_byte");
        start = 1'b0;
        @(negedge clk_25m);
        check("t2_idle_tr_end", 32'(tr_end), 32'd0);
        check("t2_idle_busy", 32'(busy), 32'd0);

        // 3: slave NACKs byte 1
        nack_mask = 4'b0010;
        push_word(32'h7830_0882, 2);
        s0 = starts; p0 = stops;
        start = 1'b1;
        wait_tr_end("t3_tr_end");
        check("t3_ack_err", 32'(ack_err), 32'd1);
        check("t3_scl_rises", 32'(last_rises), 32'd19);
        check("t3_stops", 32'(stops - p0), 32'd1);
        check("t3_starts", 32'(starts - s0), 32'd1);
        drain("t3_byte");

        // 4: hold start after tr_end, then drop and re-request
        r0 = total_rises; s0 = starts; drops = 0;
        repeat (50) begin
            @(negedge clk_25m);
            if (tr_end !== 1'b1) drops++;
        end
        check("t4_hold_drops", 32'(drops), 32'd0);
        check("t4_no_new_scl", 32'(total_rises - r0), 32'd0);
        check("t4_no_new_start", 32'(starts - s0), 32'd0);
        start = 1'b0;
        @(negedge clk_25m);
        check("t4_drop_tr_end", 32'(tr_end), 32'd0);
        check("t4_drop_busy", 32'(busy), 32'd0);
        check("t4_ack_err_hold", 32'(ack_err), 32'd1);
        nack_mask = 4'b0000;
        i2c_data  = 32'h7830_0A55;
        push_word(32'h7830_0A55, 4);
        start = 1'b1;
        wait_busy("t4_accept");
        @(negedge clk_25m);
        check("t4_ack_err_clr", 32'(ack_err), 32'd0);
        i2c_data = 32'hDEAD_BEEF;
        wait_tr_end("t4_tr_end");
        check("t4_ack_err", 32'(ack_err), 32'd0);
        drain("t4_byte");

        // start dropped mid-transfer: tr_end pulses for one clock
        start = 1'b0;
        @(negedge clk_25m);
        i2c_data = 32'h7812_3456;
        push_word(32'h7812_3456, 4);
        start = 1'b1;
        wait_busy("t4b_accept");
        repeat (20) @(negedge clk_25m);
        start = 1'b0;
        for (int i = 0; i < 4 * FRAME_CYC && tr_end !== 1'b1; i++) @(negedge clk_25m);
        check("t4b_pulse_hi", 32'(tr_end), 32'd1);
        @(negedge clk_25m);
        check("t4b_pulse_lo", 32'(tr_end), 32'd0);
        check("t4b_idle_busy", 32'(busy), 32'd0);
        drain("t4b_byte");

        // 5: reset in the middle of byte 2
        i2c_data = 32'h7830_0882;
        push_word(32'h7830_0882, 2);
        start = 1'b1;
        for (int i = 0; i < 4 * FRAME_CYC && !(byte_idx == 2 && bitpos == 3 && i2c_sclk == 1'b0); i++)
            @(negedge clk_25m);
        check("t5_reached_byte2", 32'(byte_idx), 32'd2);
        camera_rstn = 1'b0;
        @(negedge clk_25m);
        check("t5_rst_scl", 32'(i2c_sclk), 32'd1);
        check("t5_rst_sda", 32'(sda_w), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        drain("t5_abort_byte");
        i2c_data = 32'h7831_0011;
        push_word(32'h7831_0011, 4);
        s0 = starts; p0 = stops;
        camera_rstn = 1'b1;
        wait_tr_end("t5_tr_end");
        check("t5_starts", 32'(starts - s0), 32'd1);
        check("t5_stops", 32'(stops - p0), 32'd1);
        check("t5_scl_rises", 32'(last_rises), 32'd37);
        check("t5_ack_err", 32'(ack_err), 32'd0);
        drain("t5_byte");
        start = 1'b0;
        @(negedge clk_25m);

        // 6: bus protocol over the whole run
        check("bus_violations", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
